// File: rtl/codificador_param_if.sv
// codificador_param_if: producer/consumer bus of the parametrised code converter.
// The parity signal exists only when CODIFICADOR_PARITY_EN is defined.
interface codificador_param_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic             err;
  logic [CW-1:0]    count;
`ifdef CODIFICADOR_PARITY_EN
  logic             parity;
`endif

  // Producer and consumer side (testbench / surrounding logic)
  modport master (
    output in_valid, din, mode, out_ready,
`ifdef CODIFICADOR_PARITY_EN
    input  parity,
`endif
    input  in_ready, out_valid, dout, err, count
  );

  // Converter side
  modport slave (
    input  in_valid, din, mode, out_ready,
`ifdef CODIFICADOR_PARITY_EN
    output parity,
`endif
    output in_ready, out_valid, dout, err, count
  );
endinterface

// File: rtl/codificador_param.sv
// codificador_param: converts WIDTH-bit words to binary / Gray / excess-3 /
// two's-complement codes and queues them, with an overflow flag, in a
// DEPTH-entry circular FIFO. Defining CODIFICADOR_PARITY_EN adds a stored
// even-parity bit per entry, presented on bus.parity.
module codificador_param #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  codificador_param_if.slave bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
`ifdef CODIFICADOR_PARITY_EN
  localparam int unsigned EW = WIDTH + 2;
`else
  localparam int unsigned EW = WIDTH + 1;
`endif
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [PW-1:0]    LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);

  // Storage and pointers
  logic [EW-1:0]    mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    cnt;

  // Registered outputs
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] dout_q;
  logic             err_q;
`ifdef CODIFICADOR_PARITY_EN
  logic             parity_q;
`endif

  // Combinational helpers
  logic             push_c;
  logic             pop_c;
  logic [WIDTH-1:0] code_c;
  logic             ovf_c;
  logic [WIDTH:0]   sum_c;
  logic [EW-1:0]    entry_c;
  logic [PW-1:0]    wptr_n;
  logic [PW-1:0]    rptr_n;
  logic [CW-1:0]    cnt_n;
  logic [EW-1:0]    head_n;

  // Handshake decisions depend only on registered flags, never on out_ready->in_ready
  always_comb begin
    push_c = bus.in_valid && in_ready_q;
    pop_c  = out_valid_q && bus.out_ready;
  end

  // Code conversion of the offered word
  always_comb begin
    code_c = bus.din;
    ovf_c  = 1'b0;
    sum_c  = {1'b0, bus.din} + (WIDTH+1)'(3);
    case (bus.mode)
      2'b00: begin
        code_c = bus.din;
        ovf_c  = 1'b0;
      end
      2'b01: begin
        code_c = bus.din ^ (bus.din >> 1);
        ovf_c  = 1'b0;
      end
      2'b10: begin
        code_c = sum_c[WIDTH-1:0];
        ovf_c  = sum_c[WIDTH];
      end
      default: begin
        code_c = ~bus.din + WIDTH'(1);
        ovf_c  = (bus.din == MOST_NEG);
      end
    endcase
  end

  // Pack the FIFO entry: {[parity,] err, code}
  always_comb begin
`ifdef CODIFICADOR_PARITY_EN
    entry_c = {^code_c, ovf_c, code_c};
`else
    entry_c = {ovf_c, code_c};
`endif
  end

  // Next pointer and occupancy values with explicit wrap at DEPTH-1
  always_comb begin
    wptr_n = wptr;
    rptr_n = rptr;
    cnt_n  = cnt;
    if (push_c) begin
      wptr_n = (wptr == LAST_IDX) ? '0 : wptr + PW'(1);
    end
    if (pop_c) begin
      rptr_n = (rptr == LAST_IDX) ? '0 : rptr + PW'(1);
    end
    case ({push_c, pop_c})
      2'b10:   cnt_n = cnt + CW'(1);
      2'b01:   cnt_n = cnt - CW'(1);
      default: cnt_n = cnt;
    endcase
  end

  // Head slot as it will be after this edge; a word written into that slot now bypasses the array
  always_comb begin
    if (push_c && (wptr == rptr_n)) begin
      head_n = entry_c;
    end else begin
      head_n = mem[rptr_n];
    end
  end

  // FIFO storage; cleared on reset so an empty FIFO never presents X
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (push_c) begin
      mem[wptr] <= entry_c;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      cnt  <= cnt_n;
    end
  end

  // Output registers, loaded with the next-cycle view of the FIFO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      err_q       <= 1'b0;
`ifdef CODIFICADOR_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      in_ready_q  <= (cnt_n != FULL_CNT);
      out_valid_q <= (cnt_n != '0);
      dout_q      <= head_n[WIDTH-1:0];
      err_q       <= head_n[WIDTH];
`ifdef CODIFICADOR_PARITY_EN
      parity_q    <= head_n[WIDTH+1];
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.err       = err_q;
  assign bus.count     = cnt;
`ifdef CODIFICADOR_PARITY_EN
  assign bus.parity    = parity_q;
`endif

endmodule

// File: doc/codificador_param.md
# codificador_param

Parametrised, pipelined successor to the 4-bit coding-system encoder: accepts WIDTH-bit binary words over a valid/ready handshake, converts each to one of four selectable codes, and queues the results in a DEPTH-entry output FIFO with a per-word overflow flag. It sits between the switch/input capture logic and the display/decoder stage of the coding system, decoupling producer and consumer rates.

## Interface
- WIDTH, 4, data word width in bits (≥2)
- DEPTH, 4, output FIFO depth in entries (power of two, ≥2)
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- in_valid  input  1  producer offers din/mode this cycle
- in_ready  output  1  block can accept a word this cycle (= FIFO not full)
- din  input  WIDTH  binary input word
- mode  input  2  code select, sampled with din on acceptance
- out_valid  output  1  dout/err hold a valid queued result (= FIFO not empty)
- out_ready  input  1  consumer takes the head word this cycle
- dout  output  WIDTH  encoded word at FIFO head
- err  output  1  overflow flag of the head word
- count  output  $clog2(DEPTH+1)  current FIFO occupancy

## Operation
- Acceptance: in_valid && in_ready at a rising edge; din and mode are encoded and written to the FIFO tail in that same edge.
- Modes (all arithmetic modulo 2^WIDTH):
  - 00 binary: dout = din, err = 0
  - 01 Gray: dout = din ^ (din >> 1), err = 0
  - 10 excess-3: dout = din + 3, err = carry out of bit WIDTH-1 (din > 2^WIDTH-4)
  - 11 two's complement: dout = ~din + 1, err = 1 only when din = 100…0 (most negative value)
- Each FIFO entry stores WIDTH+1 bits (code + err); mode is not stored.
- Pop: out_valid && out_ready at a rising edge removes the head; the next entry appears on dout/err in the following cycle.
- FIFO: circular buffer, read/write pointers wrap from DEPTH-1 to 0; count = occupancy 0..DEPTH.
- Full (count = DEPTH): in_ready = 0; a push is not accepted even if a pop occurs that cycle (in_ready depends only on current count, no combinational out_ready→in_ready path).
- Empty (count = 0): out_valid = 0; out_ready is ignored; dout/err are don't-care to the consumer but are driven from the head slot (no X).
- Simultaneous push and pop with 0 < count < DEPTH: both occur, count unchanged.
- in_valid with in_ready = 0: no effect; producer holds din/mode stable until accepted.
- Reset (asynchronous, any time, including mid-transfer): pointers and count to 0, all storage to 0; immediately out_valid = 0, in_ready = 1, dout = 0, err = 0, count = 0. Words in flight are discarded.

## Timing
- Latency: word accepted at edge n is visible on dout/err with out_valid = 1 after edge n (i.e. in cycle n+1) when the FIFO was empty.
- Throughput: one accept and one pop per cycle sustained.
- in_ready, out_valid, count, dout, err are functions of registered state only.
- Reset deassertion: first acceptance possible at the first rising edge after reset falls.

## Configuration
- CODIFICADOR_PARITY_EN defined: extra output port parity (1 bit) = even parity of dout (XOR of all dout bits) for the head word, stored per entry (entry width WIDTH+2); parity = 0 in reset.
- Not defined: parity port and storage absent; all other behaviour identical.

## Test plan
- Reset then mode 01, din = 4'b0110, out_ready = 1 -> next cycle out_valid = 1, dout = 4'b0101, err = 0; one cycle later out_valid = 0.
- Mode 10 sweep din = 0..15 (WIDTH = 4) -> dout = din+3 mod 16; err = 1 exactly for din = 13, 14, 15 (dout = 0, 1, 2).
- Mode 11, din = 4'b1000 -> dout = 4'b1000, err = 1; din = 4'b0001 -> dout = 4'b1111, err = 0; mode 00, din = 9 -> dout = 9.
- out_ready = 0, push 5 words (DEPTH = 4) -> 4 accepted, count = 4, in_ready = 0 on 5th; then out_ready = 1 -> words popped in order, count 4→0, pointers wrap correctly on refill.
- Full FIFO with in_valid = 1 and out_ready = 1 same cycle -> pop only, count = 3, in_ready = 1 next cycle; half-full simultaneous push/pop -> count unchanged, order preserved.
- Assert reset asynchronously mid-burst (between edges, count = 3) -> out_valid = 0, count = 0, dout = 0 immediately; after release first new word emerges with correct code; with CODIFICADOR_PARITY_EN, dout = 4'b0111 -> parity = 1.
